// File: rtl/narrow_fifo.sv
// narrow_fifo: width-down synchronous FIFO. Wide words are written whole and
// read back one narrow lane at a time, least-significant lane first. A wide
// slot is released only when its last lane has been read.
module narrow_fifo #(
   parameter int DEPTH_LG2    = 4,
   parameter int WRDATA_WIDTH = 32,
   parameter int RDDATA_WIDTH = 16,
   parameter bit RST_MEM      = 1'b0,
   parameter bit REJECT_ERR   = 1'b1   // report rejected accesses in simulation
) (
   input  logic                                 wrclk,
   input  logic                                 rst_n,
   input  logic                                 wren_i,
   input  logic [WRDATA_WIDTH-1:0]              wdata_i,
   output logic                                 full_o,
   input  logic                                 rden_i,
   output logic [RDDATA_WIDTH-1:0]              rdata_o,
   output logic                                 empty_o,
   output logic [DEPTH_LG2+$clog2(WRDATA_WIDTH/RDDATA_WIDTH):0] level_o,
   output logic                                 ovf_o,
   output logic                                 udf_o
);

   localparam int RATIO     = WRDATA_WIDTH / RDDATA_WIDTH;
   localparam int RATIO_LG2 = $clog2(RATIO);
   localparam int DEPTH     = 1 << DEPTH_LG2;
   localparam int LVL_W     = DEPTH_LG2 + RATIO_LG2 + 1;

   logic [WRDATA_WIDTH-1:0] mem_q [DEPTH];

   // wrptr counts wide words, rdptr counts lanes; both carry a wrap bit as MSB
   logic [DEPTH_LG2:0]      wrptr_q, wrptr_d;
   logic [LVL_W-1:0]        rdptr_q, rdptr_d;
   logic [RDDATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                    ovf_q, ovf_d;
   logic                    udf_q, udf_d;

   logic [LVL_W-1:0]        wrlane;      // write pointer expressed in lanes
   logic [DEPTH_LG2-1:0]    rd_widx;
   logic [RATIO_LG2-1:0]    rd_lsel;
   logic [WRDATA_WIDTH-1:0] rd_word;
   logic [RDDATA_WIDTH-1:0] lanes [RATIO];
   logic                    wr_acc, rd_acc;

   assign wrlane  = {wrptr_q, {RATIO_LG2{1'b0}}};
   assign rd_widx = rdptr_q[LVL_W-2 -: DEPTH_LG2];
   assign rd_lsel = rdptr_q[RATIO_LG2-1:0];
   assign rd_word = mem_q[rd_widx];

   for (genvar g = 0; g < RATIO; g++) begin : g_lane
      assign lanes[g] = rd_word[g*RDDATA_WIDTH +: RDDATA_WIDTH];
   end

   // Flags come straight from the registered pointers; a partially drained
   // word still counts as occupying its slot for full_o.
   assign empty_o = (rdptr_q == wrlane);
   assign full_o  = (wrptr_q[DEPTH_LG2] != rdptr_q[LVL_W-1]) &&
                    (wrptr_q[DEPTH_LG2-1:0] == rd_widx);
   assign level_o = wrlane - rdptr_q;
   assign rdata_o = rdata_q;
   assign ovf_o   = ovf_q;
   assign udf_o   = udf_q;

   assign wr_acc = wren_i && !full_o;
   assign rd_acc = rden_i && !empty_o;

   // Next-state for pointers, read lane and sticky error flags
   always_comb begin
      wrptr_d = wrptr_q;
      rdptr_d = rdptr_q;
      rdata_d = rdata_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      if (wr_acc) wrptr_d = wrptr_q + 1'b1;
      else if (wren_i) ovf_d = 1'b1;
      if (rd_acc) begin
         rdptr_d = rdptr_q + 1'b1;
         rdata_d = lanes[rd_lsel];
      end else if (rden_i) begin
         udf_d = 1'b1;
      end
   end

   // Control state, cleared synchronously; inputs ignored while in reset
   always_ff @(posedge wrclk) begin
      if (!rst_n) begin
         wrptr_q <= '0;
         rdptr_q <= '0;
         rdata_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wrptr_q <= wrptr_d;
         rdptr_q <= rdptr_d;
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage: written on accepted writes, cleared on reset only when RST_MEM
   always_ff @(posedge wrclk) begin
      if (!rst_n) begin
         if (RST_MEM) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         end
      end else if (wr_acc) begin
         mem_q[wrptr_q[DEPTH_LG2-1:0]] <= wdata_i;
      end
   end

`ifndef SYNTHESIS
   if (REJECT_ERR) begin : g_reject_msg
      // Flag every rejected access as it happens
      always_ff @(posedge wrclk) begin
         if (rst_n && wren_i && full_o) $error("narrow_fifo: write while full");
         if (rst_n && rden_i && empty_o) $error("narrow_fifo: read while empty");
      end
   end
`endif

endmodule

// File: tb/tb_narrow_fifo.sv
// tb_narrow_fifo: directed scenario bench for narrow_fifo (32-bit in, 16-bit out,
// 16 wide words deep).
module tb_narrow_fifo;

   logic        wrclk = 1'b0;
   logic        rst_n;
   logic        wren_i;
   logic [31:0] wdata_i;
   logic        full_o;
   logic        rden_i;
   logic [15:0] rdata_o;
   logic        empty_o;
   logic [5:0]  level_o;
   logic        ovf_o;
   logic        udf_o;

   int n_checks = 0;
   int n_fail   = 0;

   narrow_fifo #(
      .DEPTH_LG2(4), .WRDATA_WIDTH(32), .RDDATA_WIDTH(16),
      .RST_MEM(1'b0), .REJECT_ERR(1'b0)
   ) dut (
      .wrclk(wrclk), .rst_n(rst_n), .wren_i(wren_i), .wdata_i(wdata_i),
      .full_o(full_o), .rden_i(rden_i), .rdata_o(rdata_o), .empty_o(empty_o),
      .level_o(level_o), .ovf_o(ovf_o), .udf_o(udf_o)
   );

   always #5 wrclk = ~wrclk;

   task automatic step;
      @(posedge wrclk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; wren_i = 1'b1; rden_i = 1'b1; wdata_i = 32'h1234_5678;
      step; step;
      n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty_o); end
      n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full_o); end
      n_checks++; if (level_o !== 6'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level_o); end
      n_checks++; if (rdata_o !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0000", rdata_o); end
      n_checks++; if (ovf_o !== 1'b0 || udf_o !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got ovf=%b udf=%b exp 0 0", ovf_o, udf_o); end
      rst_n = 1'b1; wren_i = 1'b0; rden_i = 1'b0;
   endtask

   task automatic test_basic;
      wren_i = 1'b1; wdata_i = 32'hBBBB_AAAA; step; wren_i = 1'b0;
      n_checks++; if (level_o !== 6'd2) begin n_fail++; $display("FAIL basic_level2 got %0d exp 2", level_o); end
      n_checks++; if (empty_o !== 1'b0) begin n_fail++; $display("FAIL basic_not_empty got %b exp 0", empty_o); end
      rden_i = 1'b1; step;
      n_checks++; if (rdata_o !== 16'hAAAA) begin n_fail++; $display("FAIL basic_lane0 got %h exp aaaa", rdata_o); end
      n_checks++; if (level_o !== 6'd1) begin n_fail++; $display("FAIL basic_level1 got %0d exp 1", level_o); end
      step; rden_i = 1'b0;
      n_checks++; if (rdata_o !== 16'hBBBB) begin n_fail++; $display("FAIL basic_lane1 got %h exp bbbb", rdata_o); end
      n_checks++; if (level_o !== 6'd0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL basic_drained got level=%0d empty=%b exp 0 1", level_o, empty_o); end
      step;
      n_checks++; if (rdata_o !== 16'hBBBB) begin n_fail++; $display("FAIL basic_hold got %h exp bbbb", rdata_o); end
   endtask

   task automatic test_fill_overflow;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL fill_early_full word %0d got %b exp 0", i, full_o); end
         wren_i = 1'b1; wdata_i = {16'hB000 + 16'(i), 16'hA000 + 16'(i)}; step;
      end
      n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full_o); end
      n_checks++; if (level_o !== 6'd32) begin n_fail++; $display("FAIL fill_level got %0d exp 32", level_o); end
      n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pre got %b exp 0", ovf_o); end
      wdata_i = 32'hFFFF_EEEE; step; wren_i = 1'b0;
      n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", ovf_o); end
      n_checks++; if (level_o !== 6'd32 || full_o !== 1'b1) begin n_fail++; $display("FAIL ovf_state got level=%0d full=%b exp 32 1", level_o, full_o); end
   endtask

   task automatic test_full_release;
      rden_i = 1'b1; step;
      n_checks++; if (rdata_o !== 16'hA000) begin n_fail++; $display("FAIL rel_lane0 got %h exp a000", rdata_o); end
      n_checks++; if (full_o !== 1'b1 || level_o !== 6'd31) begin n_fail++; $display("FAIL rel_partial got full=%b level=%0d exp 1 31", full_o, level_o); end
      step;
      n_checks++; if (rdata_o !== 16'hB000) begin n_fail++; $display("FAIL rel_lane1 got %h exp b000", rdata_o); end
      n_checks++; if (full_o !== 1'b0 || level_o !== 6'd30) begin n_fail++; $display("FAIL rel_freed got full=%b level=%0d exp 0 30", full_o, level_o); end
      for (int i = 1; i < 16; i++) begin
         step;
         n_checks++; if (rdata_o !== 16'hA000 + 16'(i)) begin n_fail++; $display("FAIL drain_lo word %0d got %h exp %h", i, rdata_o, 16'hA000 + 16'(i)); end
         step;
         n_checks++; if (rdata_o !== 16'hB000 + 16'(i)) begin n_fail++; $display("FAIL drain_hi word %0d got %h exp %h", i, rdata_o, 16'hB000 + 16'(i)); end
      end
      rden_i = 1'b0;
      n_checks++; if (empty_o !== 1'b1 || level_o !== 6'd0) begin n_fail++; $display("FAIL drain_empty got empty=%b level=%0d exp 1 0", empty_o, level_o); end
      n_checks++; if (ovf_o !== 1'b1 || udf_o !== 1'b0) begin n_fail++; $display("FAIL drain_sticky got ovf=%b udf=%b exp 1 0", ovf_o, udf_o); end
   endtask

   task automatic test_simultaneous;
      wren_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wdata_i = {16'hD000 + 16'(i), 16'hC000 + 16'(i)}; step;
      end
      wren_i = 1'b0; rden_i = 1'b1; step;
      n_checks++; if (rdata_o !== 16'hC000 || full_o !== 1'b1) begin n_fail++; $display("FAIL sim_pre got rdata=%h full=%b exp c000 1", rdata_o, full_o); end
      wren_i = 1'b1; wdata_i = 32'hDEAD_BEEF; step; wren_i = 1'b0;
      n_checks++; if (rdata_o !== 16'hD000) begin n_fail++; $display("FAIL sim_full_read got %h exp d000", rdata_o); end
      n_checks++; if (level_o !== 6'd30 || full_o !== 1'b0) begin n_fail++; $display("FAIL sim_full_drop got level=%0d full=%b exp 30 0", level_o, full_o); end
      for (int i = 1; i < 16; i++) begin
         step;
         n_checks++; if (rdata_o !== 16'hC000 + 16'(i)) begin n_fail++; $display("FAIL sim_drain_lo word %0d got %h exp %h", i, rdata_o, 16'hC000 + 16'(i)); end
         step;
         n_checks++; if (rdata_o !== 16'hD000 + 16'(i)) begin n_fail++; $display("FAIL sim_drain_hi word %0d got %h exp %h", i, rdata_o, 16'hD000 + 16'(i)); end
      end
      n_checks++; if (empty_o !== 1'b1 || udf_o !== 1'b0) begin n_fail++; $display("FAIL sim_empty got empty=%b udf=%b exp 1 0", empty_o, udf_o); end
      wren_i = 1'b1; wdata_i = 32'h1234_5678; step; wren_i = 1'b0;
      n_checks++; if (udf_o !== 1'b1) begin n_fail++; $display("FAIL sim_udf got %b exp 1", udf_o); end
      n_checks++; if (level_o !== 6'd2) begin n_fail++; $display("FAIL sim_empty_level got %0d exp 2", level_o); end
      n_checks++; if (rdata_o !== 16'hD00F) begin n_fail++; $display("FAIL sim_rdata_hold got %h exp d00f", rdata_o); end
      step;
      n_checks++; if (rdata_o !== 16'h5678) begin n_fail++; $display("FAIL sim_rt_lo got %h exp 5678", rdata_o); end
      step; rden_i = 1'b0;
      n_checks++; if (rdata_o !== 16'h1234 || empty_o !== 1'b1) begin n_fail++; $display("FAIL sim_rt_hi got %h empty=%b exp 1234 1", rdata_o, empty_o); end
   endtask

   task automatic test_stream;
      logic [15:0] q[$];
      logic [15:0] exp_lane;
      int wr_cnt = 0, rd_cnt = 0, lvl = 0, cyc = 0;
      bit do_wr, do_rd, wacc, racc, full_m, empty_m;
      while (rd_cnt < 80 && cyc < 3000) begin
         do_wr = (wr_cnt < 40) && ($urandom_range(0, 2) != 0);
         do_rd = ($urandom_range(0, 1) != 0);
         full_m  = (lvl >= 31);
         empty_m = (lvl == 0);
         wacc = do_wr && !full_m;
         racc = do_rd && !empty_m;
         wren_i = do_wr; rden_i = do_rd;
         wdata_i = {16'h7000 + 16'(wr_cnt), 16'h6000 + 16'(wr_cnt)};
         step;
         if (wacc) begin
            q.push_back(16'h6000 + 16'(wr_cnt));
            q.push_back(16'h7000 + 16'(wr_cnt));
            wr_cnt++;
            lvl += 2;
         end
         if (racc) begin
            exp_lane = q.pop_front();
            lvl -= 1;
            rd_cnt++;
            n_checks++; if (rdata_o !== exp_lane) begin n_fail++; $display("FAIL stream_data lane %0d got %h exp %h", rd_cnt, rdata_o, exp_lane); end
         end
         n_checks++; if (level_o !== 6'(lvl)) begin n_fail++; $display("FAIL stream_level cycle %0d got %0d exp %0d", cyc, level_o, lvl); end
         n_checks++; if (empty_o !== (lvl == 0) || full_o !== (lvl >= 31)) begin n_fail++; $display("FAIL stream_flags cycle %0d got empty=%b full=%b exp %b %b", cyc, empty_o, full_o, lvl == 0, lvl >= 31); end
         cyc++;
      end
      wren_i = 1'b0; rden_i = 1'b0;
      n_checks++; if (rd_cnt != 80) begin n_fail++; $display("FAIL stream_timeout got %0d lanes exp 80", rd_cnt); end
   endtask

   task automatic test_reset_mid;
      wren_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wdata_i = 32'h1111_0000 * (i + 1); step;
      end
      wren_i = 1'b0; rden_i = 1'b1; step; rden_i = 1'b0;
      n_checks++; if (level_o !== 6'd7) begin n_fail++; $display("FAIL mid_level_pre got %0d exp 7", level_o); end
      n_checks++; if (ovf_o !== 1'b1 || udf_o !== 1'b1) begin n_fail++; $display("FAIL mid_sticky_pre got ovf=%b udf=%b exp 1 1", ovf_o, udf_o); end
      rst_n = 1'b0; wren_i = 1'b1; rden_i = 1'b1; wdata_i = 32'h5555_AAAA; step;
      n_checks++; if (empty_o !== 1'b1 || full_o !== 1'b0 || level_o !== 6'd0) begin n_fail++; $display("FAIL mid_rst_ptr got empty=%b full=%b level=%0d exp 1 0 0", empty_o, full_o, level_o); end
      n_checks++; if (rdata_o !== 16'h0) begin n_fail++; $display("FAIL mid_rst_rdata got %h exp 0000", rdata_o); end
      n_checks++; if (ovf_o !== 1'b0 || udf_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_sticky got ovf=%b udf=%b exp 0 0", ovf_o, udf_o); end
      rst_n = 1'b1; wren_i = 1'b1; rden_i = 1'b0; wdata_i = 32'hCAFE_F00D; step;
      wren_i = 1'b0; rden_i = 1'b1; step;
      n_checks++; if (rdata_o !== 16'hF00D) begin n_fail++; $display("FAIL mid_rt_lo got %h exp f00d", rdata_o); end
      step; rden_i = 1'b0;
      n_checks++; if (rdata_o !== 16'hCAFE || empty_o !== 1'b1) begin n_fail++; $display("FAIL mid_rt_hi got %h empty=%b exp cafe 1", rdata_o, empty_o); end
   endtask

   initial begin
      rst_n = 1'b0; wren_i = 1'b0; rden_i = 1'b0; wdata_i = '0;
      test_reset;
      test_basic;
      test_fill_overflow;
      test_full_release;
      test_simultaneous;
      test_stream;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
